instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Consumer of the instruction-memory wrapper: walks a program of num_inst instructions held in DDR at base_addr,
//  one block of BLOCK_INSTS at a time. Per block it requests the block load (toggle on decoder_ld_req_in),
//  waits for imem_block_ready, reads the block out word by word, and hands each instruction to the decoder
//  on a valid/ready interface. It then pulses imem_rd_block_done and moves to the next block.
// PARAMETERS
//  INST_DATA_WIDTH  32    instruction width; bytes/inst IB = INST_DATA_WIDTH/8
//  INST_ADDR_WIDTH  10    instruction-memory word address width
//  BLOCK_INSTS      1024  instructions per block; must be <= 2**INST_ADDR_WIDTH
//  AXI_ADDR_WIDTH   42    DDR byte address width
//  MEM_REQ_W        16    load-size width in bytes; BLOCK_INSTS*IB must fit
//  CNT_W            32    instruction-count width
// PORTS
//  clk                 in   1       clock
//  reset               in   1       asynchronous, active-high reset
//  start               in   1       1-cycle pulse, latches base_addr/num_inst; ignored unless IDLE
//  base_addr           in   AXI_ADDR_WIDTH  DDR byte address of instruction 0
//  num_inst            in   CNT_W   total instructions
//  decoder_ld_addr     out  AXI_ADDR_WIDTH  block load address
//  decoder_ld_req_size out  MEM_REQ_W       block load size in bytes
//  decoder_ld_req_in   out  1       level toggled once per load request
//  imem_block_ready    in   1       block resident in instruction memory
//  imem_rd_req         out  1       1-cycle read strobe
//  imem_rd_addr        out  INST_ADDR_WIDTH  word index within block
//  imem_rd_data        in   INST_DATA_WIDTH  read data
//  imem_rd_valid       in   1       read data valid, >=1 cycle after imem_rd_req
//  imem_rd_block_done  out  1       1-cycle pulse after the block's last instruction is accepted
//  inst_data           out  INST_DATA_WIDTH  instruction to decoder
//  inst_valid          out  1       inst_data valid
//  inst_ready          in   1       decoder accepts when inst_valid&inst_ready
//  inst_last           out  1       qualifies the program's final instruction
//  fetch_busy          out  1       high from accepted start to fetch_done
//  fetch_done          out  1       1-cycle pulse, program fully delivered
// BEHAVIOUR
//  Reset: every output 0; toggle level 0; state IDLE. Reset mid-operation abandons the block; no done pulse.
//  FSM states: IDLE, LOAD, WAIT_RDY, FETCH, BLK_DONE, DONE.
//   IDLE -start & num_inst==0-> DONE. IDLE -start-> LOAD; latch base, remaining=num_inst, blk=0.
//   LOAD, one cycle: toggle decoder_ld_req_in; drive addr = base + blk*BLOCK_INSTS*IB and
//    cnt = min(remaining, BLOCK_INSTS), size = cnt*IB. Addr/size stay stable until the next LOAD. -> WAIT_RDY.
//   WAIT_RDY -imem_block_ready-> FETCH; word=0.
//   FETCH: at most one read outstanding. Issue rd_req(addr=word) when nothing is outstanding and
//    (!inst_valid | (inst_valid&inst_ready)). On imem_rd_valid, load the output register and set inst_valid.
//    Hold inst_data stable while inst_valid & !inst_ready. Ignore imem_rd_valid when nothing is outstanding.
//    Stop issuing once word==cnt. On handshake of the block's last instruction -> BLK_DONE.
//   BLK_DONE, one cycle: pulse imem_rd_block_done; remaining-=cnt; blk+=1; remaining==0 -> DONE, else -> LOAD.
//   DONE, one cycle: pulse fetch_done, drop fetch_busy -> IDLE.
//  inst_last = inst_valid & final word of final block.
//  Latency: LOAD-to-toggle 1 cycle; with 1-cycle memory and inst_ready=1, 1 instruction per 2 cycles.
//  Arithmetic is unsigned. The address sum wraps modulo 2**AXI_ADDR_WIDTH.
//  start during a busy run is ignored. start in the same cycle as DONE is ignored (FSM not yet IDLE).
// STRUCTURE
//  Package genesys_fetch_pkg holds: fetch FSM state enum, IB localparam, min() function.
//  One natural sub-module: fetch_out_reg (1-entry valid/ready output register with the hold rule).
//  Everything else stays flat in this module.
// TESTING
//  num_inst=5, BLOCK_INSTS=4, base=0x1000 -> loads (0x1000,16B) then (0x1010,4B); 5 insts in order;
//   2 block_done pulses; inst_last on inst 5; one fetch_done.
//  num_inst=0 -> no toggle, no rd_req; fetch_done 1 cycle after IDLE samples start.
//  inst_ready low 10 cycles mid-block -> inst_data held stable; no extra rd_req; no loss or duplicates.
//  imem_rd_valid delayed 3 cycles -> one outstanding read only; the order is preserved.
//  start pulsed while busy -> ignored; async reset in FETCH -> all outputs 0 immediately; clean rerun.
//  num_inst=8, BLOCK_INSTS=4 -> exact multiple: 2 loads of 16B each; no zero-size load.

Source files
------------

// File: rtl/genesys_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package genesys_fetch_pkg;

    // Bytes per instruction for the default 32-bit instruction word.
    localparam int IB = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_RDY,
        S_FETCH,
        S_BLK_DONE,
        S_DONE
    } fetch_state_e;

    // Unsigned minimum, used to size the final (possibly partial) block.
    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register. Holds its data while valid and not accepted.
module fetch_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Load has priority; a handshake empties the entry, otherwise contents are held.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Walks a program in DDR block by block: requests each block load, reads the
// resident block word by word and hands instructions to the decoder.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_LOAD     | one cycle: toggle load request, publish block address/size
// S_WAIT_RDY | waiting for the block to become resident
// S_FETCH    | reading words and delivering them over valid/ready
// S_BLK_DONE | one cycle: block released, advance to the next block
// S_DONE     | one cycle: program delivered
module instruction_fetch_unit
    import genesys_fetch_pkg::*;
#(
    parameter int INST_DATA_WIDTH = IB * 8,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int BLOCK_INSTS     = 1024,
    parameter int AXI_ADDR_WIDTH  = 42,
    parameter int MEM_REQ_W       = 16,
    parameter int CNT_W           = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [AXI_ADDR_WIDTH-1:0]  base_addr,
    input  logic [CNT_W-1:0]           num_inst,
    output logic [AXI_ADDR_WIDTH-1:0]  decoder_ld_addr,
    output logic [MEM_REQ_W-1:0]       decoder_ld_req_size,
    output logic                       decoder_ld_req_in,
    input  logic                       imem_block_ready,
    output logic                       imem_rd_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
    input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
    input  logic                       imem_rd_valid,
    output logic                       imem_rd_block_done,
    output logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic                       inst_last,
    output logic                       fetch_busy,
    output logic                       fetch_done
);

    localparam int IB_L = INST_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] BLK_BYTES = AXI_ADDR_WIDTH'(BLOCK_INSTS * IB_L);

    fetch_state_e              state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
    logic [AXI_ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
    logic [MEM_REQ_W-1:0]      ld_size_q, ld_size_d;
    logic                      tog_q, tog_d;
    logic [CNT_W-1:0]          rem_q, rem_d;
    logic [CNT_W-1:0]          blk_q, blk_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          word_q, word_d;
    logic                      out_q, out_d;
    logic [CNT_W-1:0]          blk_cnt;
    logic                      issue, load_out, words_done, blk_last_hs;

    // All words issued and nothing in flight: the entry in the output register is the block's last.
    assign words_done  = (word_q == cnt_q) && !out_q;
    assign issue       = (state_q == S_FETCH) && !out_q && (word_q != cnt_q) &&
                         (!inst_valid || inst_ready);
    assign load_out    = (state_q == S_FETCH) && out_q && imem_rd_valid;
    assign blk_last_hs = (state_q == S_FETCH) && inst_valid && inst_ready && words_done;
    assign blk_cnt     = CNT_W'(min_u32(32'(rem_q), 32'(BLOCK_INSTS)));

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        ld_addr_d = ld_addr_q;
        ld_size_d = ld_size_q;
        tog_d     = tog_q;
        rem_d     = rem_q;
        blk_d     = blk_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        out_d     = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_inst == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        base_d  = base_addr;
                        rem_d   = num_inst;
                        blk_d   = '0;
                    end
                end
            end
            S_LOAD: begin
                tog_d     = !tog_q;
                cnt_d     = blk_cnt;
                ld_addr_d = base_q + AXI_ADDR_WIDTH'(blk_q) * BLK_BYTES;
                ld_size_d = MEM_REQ_W'(blk_cnt * CNT_W'(IB_L));
                state_d   = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (imem_block_ready) begin
                    word_d  = '0;
                    out_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    word_d = word_q + CNT_W'(1);
                    out_d  = 1'b1;
                end
                if (load_out) begin
                    out_d = 1'b0;
                end
                if (blk_last_hs) begin
                    state_d = S_BLK_DONE;
                end
            end
            S_BLK_DONE: begin
                rem_d   = rem_q - cnt_q;
                blk_d   = blk_q + CNT_W'(1);
                state_d = (rem_q == cnt_q) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            ld_addr_q <= '0;
            ld_size_q <= '0;
            tog_q     <= 1'b0;
            rem_q     <= '0;
            blk_q     <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            ld_addr_q <= ld_addr_d;
            ld_size_q <= ld_size_d;
            tog_q     <= tog_d;
            rem_q     <= rem_d;
            blk_q     <= blk_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            out_q     <= out_d;
        end
    end

    fetch_out_reg #(
        .W (INST_DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (reset),
        .load_i  (load_out),
        .data_i  (imem_rd_data),
        .ready_i (inst_ready),
        .valid_o (inst_valid),
        .data_o  (inst_data)
    );

    assign decoder_ld_addr     = ld_addr_q;
    assign decoder_ld_req_size = ld_size_q;
    assign decoder_ld_req_in   = tog_q;
    assign imem_rd_req         = issue;
    assign imem_rd_addr        = word_q[INST_ADDR_WIDTH-1:0];
    assign imem_rd_block_done  = (state_q == S_BLK_DONE);
    assign inst_last           = (state_q == S_FETCH) && inst_valid && words_done && (rem_q == cnt_q);
    assign fetch_busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign fetch_done          = (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int IDW = 32;
    localparam int IAW = 10;
    localparam int BI  = 4;
    localparam int AW  = 42;
    localparam int MW  = 16;
    localparam int CW  = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [CW-1:0]  num_inst;
    logic [AW-1:0]  decoder_ld_addr;
    logic [MW-1:0]  decoder_ld_req_size;
    logic           decoder_ld_req_in;
    logic           imem_block_ready = 1'b0;
    logic           imem_rd_req;
    logic [IAW-1:0] imem_rd_addr;
    logic [IDW-1:0] imem_rd_data = '0;
    logic           imem_rd_valid = 1'b0;
    logic           imem_rd_block_done;
    logic [IDW-1:0] inst_data;
    logic           inst_valid;
    logic           inst_ready = 1'b1;
    logic           inst_last;
    logic           fetch_busy;
    logic           fetch_done;

    instruction_fetch_unit #(
        .INST_DATA_WIDTH (IDW),
        .INST_ADDR_WIDTH (IAW),
        .BLOCK_INSTS     (BI),
        .AXI_ADDR_WIDTH  (AW),
        .MEM_REQ_W       (MW),
        .CNT_W           (CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .base_addr           (base_addr),
        .num_inst            (num_inst),
        .decoder_ld_addr     (decoder_ld_addr),
        .decoder_ld_req_size (decoder_ld_req_size),
        .decoder_ld_req_in   (decoder_ld_req_in),
        .imem_block_ready    (imem_block_ready),
        .imem_rd_req         (imem_rd_req),
        .imem_rd_addr        (imem_rd_addr),
        .imem_rd_data        (imem_rd_data),
        .imem_rd_valid       (imem_rd_valid),
        .imem_rd_block_done  (imem_rd_block_done),
        .inst_data           (inst_data),
        .inst_valid          (inst_valid),
        .inst_ready          (inst_ready),
        .inst_last           (inst_last),
        .fetch_busy          (fetch_busy),
        .fetch_done          (fetch_done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // controls written by the test tasks
    logic          clr_stats = 1'b0;
    int            rd_lat = 1;
    logic          stall_arm = 1'b0;
    int            stall_at = 0;
    logic [AW-1:0] prog_base = '0;

    // observations and memory model, owned by the negedge block
    int             cyc = 0, start_cyc = 0, tog_cyc = 0, fd_cyc = 0;
    int             ld_cnt = 0, rd_cnt = 0, bd_cnt = 0, fd_cnt = 0, hs_cnt = 0;
    int             last_cnt = 0, last_idx = -1, last_err = 0, stab_err = 0;
    int             ovl_err = 0, rd_stall_err = 0, vnr_cyc = 0, busy_err = 0;
    logic [AW-1:0]  ld_addr_log[$];
    logic [MW-1:0]  ld_size_log[$];
    logic [IDW-1:0] hs_data[$];
    int             hs_cyc[$];
    int             pend = 0, rdy_dly = 0, stall_left = 0;
    logic           stall_used = 1'b0;
    logic [IDW-1:0] pend_data = '0;
    logic           tog_prev = 1'b0, prev_vnr = 1'b0;
    logic [IDW-1:0] prev_data = '0;
    logic           nx_rd_valid = 1'b0, nx_blk_rdy = 1'b0, nx_inst_ready = 1'b1;
    logic [IDW-1:0] nx_rd_data = '0;

    function automatic logic [IDW-1:0] exp_inst(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Observe the settled cycle, then plan the memory/decoder inputs for the next cycle.
    always @(negedge clk) begin
        cyc++;
        if (clr_stats) begin
            ld_cnt = 0; rd_cnt = 0; bd_cnt = 0; fd_cnt = 0; hs_cnt = 0;
            last_cnt = 0; last_idx = -1; last_err = 0; stab_err = 0;
            ovl_err = 0; rd_stall_err = 0; vnr_cyc = 0; busy_err = 0;
            ld_addr_log.delete(); ld_size_log.delete(); hs_data.delete(); hs_cyc.delete();
            stall_used = 1'b0;
        end else if (!reset) begin
            if (start) start_cyc = cyc;
            if (decoder_ld_req_in !== tog_prev) begin
                ld_addr_log.push_back(decoder_ld_addr);
                ld_size_log.push_back(decoder_ld_req_size);
                if (ld_cnt == 0) tog_cyc = cyc;
                ld_cnt++;
            end
            if (imem_rd_req) rd_cnt++;
            if (imem_rd_req && inst_valid && !inst_ready) rd_stall_err++;
            if (inst_valid && !inst_ready) vnr_cyc++;
            if (inst_valid && inst_ready) begin
                if (inst_last) begin
                    last_cnt++;
                    last_idx = hs_cnt;
                end
                hs_data.push_back(inst_data);
                hs_cyc.push_back(cyc);
                hs_cnt++;
            end
            if (inst_last && !inst_valid) last_err++;
            if (prev_vnr && (!inst_valid || inst_data !== prev_data)) stab_err++;
            if (imem_rd_block_done) bd_cnt++;
            if (fetch_done) begin
                fd_cnt++;
                fd_cyc = cyc;
                if (fetch_busy) busy_err++;
            end
        end
        if (reset) begin
            pend = 0; rdy_dly = 0; stall_left = 0;
            nx_rd_valid = 1'b0; nx_blk_rdy = 1'b0; nx_inst_ready = 1'b1;
        end else begin
            if (decoder_ld_req_in !== tog_prev) begin
                rdy_dly = 3;
            end else if (rdy_dly > 0) begin
                rdy_dly--;
                if (rdy_dly == 0) nx_blk_rdy = 1'b1;
            end
            if (imem_rd_block_done) nx_blk_rdy = 1'b0;
            if (imem_rd_req) begin
                if (pend != 0 || imem_rd_valid) ovl_err++;
                pend = rd_lat;
                pend_data = 32'hC0DE_0000 + 32'((decoder_ld_addr - prog_base) >> 2) + 32'(imem_rd_addr);
            end
            nx_rd_valid = (pend == 1);
            if (pend == 1) nx_rd_data = pend_data;
            if (pend > 0) pend--;
            if (stall_left > 0) begin
                stall_left--;
                nx_inst_ready = (stall_left == 0);
            end else if (stall_arm && !stall_used && hs_cnt == stall_at) begin
                nx_inst_ready = 1'b0;
                stall_left = 10;
                stall_used = 1'b1;
            end
        end
        tog_prev  = decoder_ld_req_in;
        prev_vnr  = inst_valid && !inst_ready;
        prev_data = inst_data;
    end

    // Apply planned inputs just after the active edge.
    always @(posedge clk) begin
        #1;
        imem_rd_valid    = nx_rd_valid;
        imem_rd_data     = nx_rd_data;
        imem_block_ready = nx_blk_rdy;
        inst_ready       = nx_inst_ready;
    end

    task automatic clear_stats();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    task automatic run_prog(input logic [AW-1:0] b, input logic [CW-1:0] n, output bit ok);
        clear_stats();
        prog_base = b;
        base_addr = b;
        num_inst  = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (fd_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string name, input int n);
        logic [IDW-1:0] got;
        for (int i = 0; i < n; i++) begin
            got = (i < hs_data.size()) ? hs_data[i] : 32'hxxxx_xxxx;
            n_total++;
            if (got !== exp_inst(i)) $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got, exp_inst(i));
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        n_total++;
        if ({decoder_ld_req_in, inst_valid, imem_rd_req, fetch_busy, fetch_done, imem_rd_block_done, inst_last} !== 7'b0)
            $display("FAIL reset_ctrl: got %b expected 0", {decoder_ld_req_in, inst_valid, imem_rd_req, fetch_busy, fetch_done, imem_rd_block_done, inst_last});
        else n_pass++;
        n_total++;
        if (decoder_ld_addr !== '0 || decoder_ld_req_size !== '0)
            $display("FAIL reset_ld: got %h/%h expected 0/0", decoder_ld_addr, decoder_ld_req_size);
        else n_pass++;
        n_total++;
        if (inst_data !== '0 || imem_rd_addr !== '0)
            $display("FAIL reset_data: got %h/%h expected 0/0", inst_data, imem_rd_addr);
        else n_pass++;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (fetch_busy !== 1'b0 || decoder_ld_req_in !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b tog=%b expected 0/0", fetch_busy, decoder_ld_req_in);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        run_prog(42'h1000, 5, ok);
        n_total++; if (!ok) $display("FAIL basic_done: got timeout expected fetch_done"); else n_pass++;
        n_total++; if (ld_cnt != 2) $display("FAIL basic_loads: got %0d expected 2", ld_cnt); else n_pass++;
        n_total++;
        if (ld_addr_log.size() < 2 || ld_addr_log[0] !== 42'h1000 || ld_size_log[0] !== 16'd16)
            $display("FAIL basic_load0: got %h/%0d expected 1000/16", (ld_addr_log.size() > 0) ? ld_addr_log[0] : '0, (ld_size_log.size() > 0) ? ld_size_log[0] : '0);
        else n_pass++;
        n_total++;
        if (ld_addr_log.size() < 2 || ld_addr_log[1] !== 42'h1010 || ld_size_log[1] !== 16'd4)
            $display("FAIL basic_load1: got %h/%0d expected 1010/4", (ld_addr_log.size() > 1) ? ld_addr_log[1] : '0, (ld_size_log.size() > 1) ? ld_size_log[1] : '0);
        else n_pass++;
        n_total++; if (hs_cnt != 5) $display("FAIL basic_count: got %0d expected 5", hs_cnt); else n_pass++;
        check_data("basic", 5);
        n_total++; if (bd_cnt != 2) $display("FAIL basic_block_done: got %0d expected 2", bd_cnt); else n_pass++;
        n_total++;
        if (last_cnt != 1 || last_idx != 4 || last_err != 0)
            $display("FAIL basic_last: got cnt=%0d idx=%0d err=%0d expected 1/4/0", last_cnt, last_idx, last_err);
        else n_pass++;
        n_total++; if (fd_cnt != 1) $display("FAIL basic_fetch_done: got %0d expected 1", fd_cnt); else n_pass++;
        n_total++; if (busy_err != 0) $display("FAIL basic_busy_at_done: got %0d expected 0", busy_err); else n_pass++;
        n_total++; if (tog_cyc - start_cyc != 2) $display("FAIL basic_toggle_latency: got %0d expected 2", tog_cyc - start_cyc); else n_pass++;
        n_total++;
        if (hs_cyc.size() < 2 || hs_cyc[1] - hs_cyc[0] != 2)
            $display("FAIL basic_rate: got %0d expected 2", (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1);
        else n_pass++;
        n_total++; if (ovl_err != 0) $display("FAIL basic_outstanding: got %0d expected 0", ovl_err); else n_pass++;
    endtask

    task automatic test_zero();
        bit ok;
        run_prog(42'h7000, 0, ok);
        n_total++; if (!ok) $display("FAIL zero_done: got timeout expected fetch_done"); else n_pass++;
        n_total++;
        if (ld_cnt != 0 || rd_cnt != 0 || hs_cnt != 0 || bd_cnt != 0)
            $display("FAIL zero_activity: got ld=%0d rd=%0d hs=%0d bd=%0d expected 0", ld_cnt, rd_cnt, hs_cnt, bd_cnt);
        else n_pass++;
        n_total++; if (fd_cyc - start_cyc != 1) $display("FAIL zero_latency: got %0d expected 1", fd_cyc - start_cyc); else n_pass++;
        n_total++; if (fd_cnt != 1) $display("FAIL zero_fetch_done: got %0d expected 1", fd_cnt); else n_pass++;
    endtask

    task automatic test_exact_multiple();
        bit ok;
        run_prog(42'h2000, 8, ok);
        n_total++; if (!ok) $display("FAIL exact_done: got timeout expected fetch_done"); else n_pass++;
        n_total++;
        if (ld_cnt != 2 || ld_addr_log.size() < 2 || ld_addr_log[0] !== 42'h2000 || ld_addr_log[1] !== 42'h2010 ||
            ld_size_log[0] !== 16'd16 || ld_size_log[1] !== 16'd16)
            $display("FAIL exact_loads: got cnt=%0d expected 2 loads 2000/16 2010/16", ld_cnt);
        else n_pass++;
        n_total++; if (hs_cnt != 8) $display("FAIL exact_count: got %0d expected 8", hs_cnt); else n_pass++;
        check_data("exact", 8);
        n_total++;
        if (last_cnt != 1 || last_idx != 7) $display("FAIL exact_last: got cnt=%0d idx=%0d expected 1/7", last_cnt, last_idx);
        else n_pass++;
        n_total++; if (bd_cnt != 2) $display("FAIL exact_block_done: got %0d expected 2", bd_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        stall_at  = 2;
        stall_arm = 1'b1;
        run_prog(42'h4000, 6, ok);
        stall_arm = 1'b0;
        n_total++; if (!ok) $display("FAIL stall_done: got timeout expected fetch_done"); else n_pass++;
        n_total++; if (vnr_cyc < 5) $display("FAIL stall_held_cycles: got %0d expected >=5", vnr_cyc); else n_pass++;
        n_total++; if (stab_err != 0) $display("FAIL stall_stable: got %0d changes expected 0", stab_err); else n_pass++;
        n_total++; if (rd_stall_err != 0) $display("FAIL stall_extra_rd: got %0d expected 0", rd_stall_err); else n_pass++;
        n_total++; if (hs_cnt != 6 || rd_cnt != 6) $display("FAIL stall_count: got hs=%0d rd=%0d expected 6/6", hs_cnt, rd_cnt); else n_pass++;
        check_data("stall", 6);
    endtask

    task automatic test_slow_mem();
        bit ok;
        rd_lat = 3;
        run_prog(42'h1000, 5, ok);
        rd_lat = 1;
        n_total++; if (!ok) $display("FAIL slow_done: got timeout expected fetch_done"); else n_pass++;
        n_total++; if (ovl_err != 0) $display("FAIL slow_outstanding: got %0d expected 0", ovl_err); else n_pass++;
        n_total++;
        if (hs_cyc.size() < 2 || hs_cyc[1] - hs_cyc[0] != 4)
            $display("FAIL slow_rate: got %0d expected 4", (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1);
        else n_pass++;
        n_total++; if (hs_cnt != 5) $display("FAIL slow_count: got %0d expected 5", hs_cnt); else n_pass++;
        check_data("slow", 5);
    endtask

    task automatic test_start_busy();
        bit ok;
        clear_stats();
        prog_base = 42'h1000;
        base_addr = 42'h1000;
        num_inst  = 5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        base_addr = 42'h9000;
        num_inst  = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (fetch_done) begin
                ok = 1'b1;
                break;
            end
        end
        base_addr = 42'h5000;
        num_inst  = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (!ok) $display("FAIL busy_done: got timeout expected fetch_done"); else n_pass++;
        n_total++; if (ld_cnt != 2) $display("FAIL busy_loads: got %0d expected 2", ld_cnt); else n_pass++;
        n_total++; if (hs_cnt != 5) $display("FAIL busy_count: got %0d expected 5", hs_cnt); else n_pass++;
        n_total++; if (fd_cnt != 1) $display("FAIL busy_fetch_done: got %0d expected 1", fd_cnt); else n_pass++;
        n_total++; if (fetch_busy !== 1'b0) $display("FAIL start_at_done: got busy=%b expected 0", fetch_busy); else n_pass++;
        check_data("busy", 5);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_stats();
        prog_base = 42'h3000;
        base_addr = 42'h3000;
        num_inst  = 8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (hs_cnt >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++; if (!ok) $display("FAIL rmid_reach_fetch: got timeout expected 2 handshakes"); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({decoder_ld_req_in, inst_valid, imem_rd_req, fetch_busy, fetch_done, inst_last} !== 6'b0)
            $display("FAIL rmid_ctrl: got %b expected 0", {decoder_ld_req_in, inst_valid, imem_rd_req, fetch_busy, fetch_done, inst_last});
        else n_pass++;
        n_total++;
        if (decoder_ld_addr !== '0 || decoder_ld_req_size !== '0 || inst_data !== '0)
            $display("FAIL rmid_data: got %h/%h/%h expected 0", decoder_ld_addr, decoder_ld_req_size, inst_data);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (fd_cnt != 0) $display("FAIL rmid_no_done: got %0d expected 0", fd_cnt); else n_pass++;
        run_prog(42'h1000, 5, ok);
        n_total++; if (!ok) $display("FAIL rerun_done: got timeout expected fetch_done"); else n_pass++;
        n_total++;
        if (ld_cnt != 2 || ld_addr_log.size() < 1 || ld_addr_log[0] !== 42'h1000)
            $display("FAIL rerun_loads: got cnt=%0d expected 2 starting at 1000", ld_cnt);
        else n_pass++;
        check_data("rerun", 5);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_inst  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_zero();
        test_exact_multiple();
        test_stall();
        test_slow_mem();
        test_start_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
